// File: rtl/imem_loader_if.sv
// Byte-stream load interface for imem_loader.
// The master (host/bench) starts a session and pushes bytes; the slave
// (the loader) accepts a byte on every edge where byte_valid && byte_ready.
interface imem_loader_if #(
  parameter int AW = 6
);
  logic          load_start;
  logic [AW:0]   load_len;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;

  modport master (
    output load_start,
    output load_len,
    output byte_valid,
    output byte_data,
    input  byte_ready
  );

  modport slave (
    input  load_start,
    input  load_len,
    input  byte_valid,
    input  byte_data,
    output byte_ready
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader for the single-cycle RISC-V core.
// Assembles a little-endian byte stream into 32-bit words, writes them into
// the instruction RAM, and holds the core in reset until the session is done.
// Also provides the core's combinational instruction read port.
// Optional feature macro: LOADER_CHECKSUM_EN (8-bit trailer checksum with
// CHECK and ERROR states); the default build has neither state.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus,
  input  logic [31:0]   a,
  output logic [31:0]   rd,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   word_count,
  output logic          checksum_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef LOADER_CHECKSUM_EN
    S_DONE,
    S_CHECK,
    S_ERROR
`else
    S_DONE
`endif
  } state_t;

  localparam logic [AW:0] MAX_LEN = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  state_t        state;
  logic [AW:0]   len;
  logic [1:0]    lane;
  logic [23:0]   assembled;
  logic [31:0]   mem [DEPTH];

  logic          xfer;
  logic          wr_en;
  logic [AW:0]   len_clamped;
  logic [AW:0]   next_count;
  logic          unused_addr_bits;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    sum;
`endif

  assign xfer        = bus.byte_valid && bus.byte_ready;
  assign wr_en       = (state == S_LOAD) && xfer && (lane == 2'd3);
  assign len_clamped = (bus.load_len > MAX_LEN) ? MAX_LEN : bus.load_len;
  assign next_count  = word_count + ONE;

  // Control FSM; all status outputs are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      cpu_reset      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.byte_ready <= 1'b0;
      word_count     <= '0;
      lane           <= 2'd0;
      assembled      <= '0;
      len            <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum            <= 8'd0;
      checksum_err   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.load_start) begin
            len        <= len_clamped;
            word_count <= '0;
            lane       <= 2'd0;
            done       <= 1'b0;
            cpu_reset  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum        <= 8'd0;
            if (len_clamped == '0) begin
              state          <= S_CHECK;
              busy           <= 1'b1;
              bus.byte_ready <= 1'b1;
            end else begin
              state          <= S_LOAD;
              busy           <= 1'b1;
              bus.byte_ready <= 1'b1;
            end
`else
            if (len_clamped == '0) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state          <= S_LOAD;
              busy           <= 1'b1;
              bus.byte_ready <= 1'b1;
            end
`endif
          end
        end
        S_LOAD: begin
          if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
            sum <= sum + bus.byte_data;
`endif
            case (lane)
              2'd0: assembled[7:0]   <= bus.byte_data;
              2'd1: assembled[15:8]  <= bus.byte_data;
              2'd2: assembled[23:16] <= bus.byte_data;
              default: ;
            endcase
            if (lane == 2'd3) begin
              lane       <= 2'd0;
              word_count <= next_count;
              if (next_count == len) begin
`ifdef LOADER_CHECKSUM_EN
                state <= S_CHECK;
`else
                state          <= S_DONE;
                busy           <= 1'b0;
                bus.byte_ready <= 1'b0;
                done           <= 1'b1;
                cpu_reset      <= 1'b0;
`endif
              end
            end else begin
              lane <= lane + 2'd1;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (xfer) begin
            busy           <= 1'b0;
            bus.byte_ready <= 1'b0;
            if (8'(sum + bus.byte_data) == 8'd0) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state        <= S_ERROR;
              checksum_err <= 1'b1;
              cpu_reset    <= 1'b1;
            end
          end
        end
        S_ERROR: begin
        end
`endif
        default: begin
          state          <= S_IDLE;
          busy           <= 1'b0;
          done           <= 1'b0;
          bus.byte_ready <= 1'b0;
          cpu_reset      <= 1'b1;
        end
      endcase
    end
  end

`ifndef LOADER_CHECKSUM_EN
  assign checksum_err = 1'b0;
`endif

  // Instruction RAM write; the fourth byte completes the word on its own edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[word_count[AW-1:0]] <= {bus.byte_data, assembled};
    end
  end

  assign rd               = mem[a[AW+1:2]];
  assign unused_addr_bits = ^{a[31:AW+2], a[1:0]};

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Instruction-memory writer for the single-cycle RISC-V core. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words into its own instruction RAM and holds the core in reset until the programmed number of words has been loaded. It also provides the core's combinational instruction read port, and replaces the $readmemh-initialised instruction memory.

Parameters:
DEPTH, 64, number of 32-bit instruction words in RAM
AW, 6, word-address width; DEPTH = 2**AW

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-high
load_start  input  1  one-cycle pulse; begins a load session
load_len  input  AW+1  words to load; sampled when load_start is accepted
byte_valid  input  1  byte_data is valid
byte_data  input  8  next stream byte
byte_ready  output  1  loader accepts a byte this cycle
a  input  32  core PC (byte address)
rd  output  32  instruction word at a
cpu_reset  output  1  reset to the core; 1 while not DONE
busy  output  1  1 in LOAD (and CHECK when the optional feature is enabled)
done  output  1  1 in DONE
word_count  output  AW+1  words written in the current session
checksum_err  output  1  1 in ERROR; tied 0 without the optional feature

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, cpu_reset=1, busy=0, done=0, byte_ready=0, word_count=0, byte lane index=0, assembly register=0. RAM contents are not reset.
- States: IDLE, LOAD, DONE, plus CHECK and ERROR when the optional feature is enabled.
- Outputs decoded from state:
  - byte_ready=1 only in LOAD or CHECK.
  - busy=1 in LOAD or CHECK.
  - done=1 in DONE.
  - cpu_reset=0 only in DONE.
- IDLE or DONE, with load_start=1:
  - Latch len = min(load_len, DEPTH).
  - Clear word_count and the lane index.
  - Go to LOAD, or to DONE if len==0.
  - cpu_reset reasserts on that edge.
- LOAD, byte transfer: a byte transfers on the rising edge where byte_valid && byte_ready. The first byte of a word goes to bits 7:0, the fourth to bits 31:24.
- LOAD, fourth byte: on the edge that transfers the fourth byte:
  - RAM[word_count[AW-1:0]] <= {byte_data, assembled[23:0]} (same edge, no extra cycle).
  - word_count increments and the lane index returns to 0.
  - If word_count+1 == len, next state is DONE (CHECK with the feature).
- Completion timing: done=1 and cpu_reset=0 in the cycle after the final byte transfers.
- load_start is ignored in LOAD, CHECK and ERROR. byte_valid outside LOAD/CHECK is ignored and no byte is consumed.
- Read port: rd = RAM[a[AW+1:2]], combinational. a[1:0] and bits above AW+1 are ignored, so addresses wrap by truncation. A read and a write to the same word in the same cycle returns the old word.
- Reset mid-load:
  - Returns to IDLE immediately and cpu_reset=1.
  - The partially assembled word is discarded.
  - Words already written remain in RAM.
- load_len > DEPTH is clamped to DEPTH; no wrap-around writes occur.

Optional Feature:
Macro: LOADER_CHECKSUM_EN
- Defined:
  - An 8-bit running sum (mod 256) of every byte accepted in LOAD is kept; it is cleared on load_start.
  - After the last word, the state goes to CHECK, where byte_ready=1 and exactly one trailer byte is accepted.
  - If (sum + trailer) mod 256 == 0, go to DONE.
  - Otherwise go to ERROR: checksum_err=1, cpu_reset=1, busy=0, done=0.
  - ERROR is left only by reset.
  - With len==0, the loader still passes through CHECK and expects trailer 0x00.
- Undefined: no CHECK or ERROR states and checksum_err is constant 0; LOAD goes directly to DONE.

Test Plan:
1. Basic load: reset, load_start with load_len=2, bytes 13 05 00 00 93 05 40 00 streamed back-to-back -> RAM[0]=0x00000513, RAM[1]=0x00400593, word_count=2. done=1 and cpu_reset=0 one cycle after the 8th byte; rd=0x00400593 at a=4 and 0x00000513 at a=0x100 (wrap).
2. Backpressure gaps: same stream with byte_valid low for 1-3 random cycles between bytes -> identical RAM contents, no duplicated or dropped bytes, byte_ready stays 1 throughout LOAD.
3. Zero length: load_len=0 -> DONE on the next edge, no RAM writes, word_count=0, byte_ready never 1 (feature undefined).
4. Clamp: load_len=100 with 260 bytes offered -> exactly 64 words written, word_count=64. byte_ready=0 after the 256th byte; bytes 257-260 are not accepted.
5. Reset mid-load: reset pulsed after 5 bytes of a 2-word load -> IDLE, cpu_reset=1, word_count=0. RAM[0] holds the first word; a following load of 1 word starts assembly at lane 0.
6. Checksum (LOADER_CHECKSUM_EN): load_len=1, bytes 01 02 03 04 then trailer 0xF6 -> done=1. Trailer 0xF7 -> checksum_err=1, cpu_reset stays 1, load_start ignored until reset.
